// File: rtl/revaluate_stage_pkg.sv
// Shared constants, FSM encoding and 5x5 plane indexing for the chi (revaluate) stage.
package revaluate_stage_pkg;

    localparam int LINES_DEF = 64;
    localparam int WIDTH_DEF = 25;
    localparam int PLANE     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Lane (x, y) of a slice lives at bit 5*y + x.
    function automatic int bit_idx(input int x, input int y);
        return PLANE * y + x;
    endfunction

endpackage

// File: rtl/chi_slice.sv
// Combinational chi step on one 5x5 slice: each row is mixed independently, no carries.
module chi_slice
    import revaluate_stage_pkg::*;
(
    input  logic [WIDTH_DEF-1:0] slice_in,
    output logic [WIDTH_DEF-1:0] slice_out
);

    always_comb begin
        slice_out = '0;
        for (int y = 0; y < PLANE; y++) begin
            for (int x = 0; x < PLANE; x++) begin
                slice_out[bit_idx(x, y)] = slice_in[bit_idx(x, y)]
                    ^ (~slice_in[bit_idx((x + 1) % PLANE, y)]
                       & slice_in[bit_idx((x + 2) % PLANE, y)]);
            end
        end
    end

endmodule

// File: rtl/revaluate_stage.sv
// Streams one full state through chi: reads LINES slices from upstream, writes results
// one cycle later to the output port and to an internal buffer read by the next stage.
module revaluate_stage
    import revaluate_stage_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int CW   = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] line_in,
    output logic [CW-1:0]    cnt_value,
    output logic             write_enable,
    output logic [CW-1:0]    write_addr,
    output logic [WIDTH-1:0] write_value,
    input  logic [CW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             donee,
    output state_t           state_dbg
);

    // Handshake: start is a level request sampled only in IDLE; write_enable qualifies
    // write_addr/write_value for exactly the cycles it is high; donee is a one-cycle pulse.

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              cnt_last;
    logic              wr_en;
    logic [CW-1:0]     wr_addr;
    logic [WIDTH-1:0]  wr_val;
    logic [WIDTH-1:0]  chi_out;
    logic [WIDTH-1:0]  res_buf [LINES];

    assign cnt_last = (cnt == CW'(LINES - 1));

    chi_slice u_chi (
        .slice_in  (line_in),
        .slice_out (chi_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        donee     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                donee     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-stage pipeline: the slice read in this RUN cycle is written in the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_val  <= '0;
        end else begin
            wr_en <= (state == RUN);
            if (state == RUN) begin
                wr_addr <= cnt;
                wr_val  <= chi_out;
                cnt     <= cnt_last ? '0 : cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Result buffer survives reset; reads see the pre-write contents during a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            res_buf[wr_addr] <= wr_val;
        end
    end

    assign rd_data      = res_buf[rd_addr];
    assign cnt_value    = cnt;
    assign write_enable = wr_en;
    assign write_addr   = wr_addr;
    assign write_value  = wr_val;
    assign state_dbg    = state;

endmodule

// File: tb/tb_revaluate_stage.sv
// Directed, table-driven bench for revaluate_stage with an upstream slice memory model.
module tb_revaluate_stage;
    import revaluate_stage_pkg::*;

    typedef struct {
        logic [24:0] fill;
        logic [5:0]  sp_addr;
        logic [24:0] sp_val;
        logic [24:0] exp_fill;
        logic [24:0] exp_sp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] line_in;
    logic [5:0]  cnt_value;
    logic        write_enable;
    logic [5:0]  write_addr;
    logic [24:0] write_value;
    logic [5:0]  rd_addr;
    logic [24:0] rd_data;
    logic        busy;
    logic        donee;
    state_t      state_dbg;

    logic [24:0] mem [64];
    logic [24:0] shadow [64];
    bit          shadow_ok = 0;
    vec_t        vecs [7];
    logic [30:0] exp_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign line_in = mem[cnt_value];

    revaluate_stage dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .line_in      (line_in),
        .cnt_value    (cnt_value),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_value  (write_value),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .donee        (donee),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] exp_val(input int v, input int a);
        return (a == int'(vecs[v].sp_addr)) ? vecs[v].exp_sp : vecs[v].exp_fill;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cnt"}, 32'(cnt_value), 32'd0);
        check({tag, "_we"}, 32'(write_enable), 32'd0);
        check({tag, "_waddr"}, 32'(write_addr), 32'd0);
        check({tag, "_wval"}, 32'(write_value), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_donee"}, 32'(donee), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_vec(input int v);
        for (int a = 0; a < 64; a++) mem[a] = vecs[v].fill;
        mem[vecs[v].sp_addr] = vecs[v].sp_val;
    endtask

    // Start one pass and watch cycles 1..66 relative to the edge that samples start.
    task automatic run_pass(input int v, input bit hold);
        int          n_wr;
        int          n_done;
        logic [30:0] e;
        load_vec(v);
        exp_q.delete();
        for (int a = 0; a < 64; a++) exp_q.push_back({6'(a), exp_val(v, a)});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n_wr   = 0;
        n_done = 0;
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (write_enable) begin
                n_wr++;
                check("wr_cycle", 32'(c), 32'(n_wr + 1));
                if (exp_q.size() == 0) begin
                    check("wr_extra", 32'(write_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(write_addr), 32'(e[30:25]));
                    check("wr_value", 32'(write_value), 32'(e[24:0]));
                end
            end
            if (donee) begin
                n_done++;
                check("done_cycle", 32'(c), 32'd66);
            end
            check("busy", 32'(busy), 32'(c <= 65));
            check("cnt_value", 32'(cnt_value), (c <= 64) ? 32'(c - 1) : 32'd0);
            if (shadow_ok && c == 12) check("rd_old", 32'(rd_data), 32'(shadow[10]));
            if (shadow_ok && c == 13) check("rd_new", 32'(rd_data), 32'(exp_val(v, 10)));
        end
        check("n_writes", 32'(n_wr), 32'd64);
        check("n_donee", 32'(n_done), 32'd1);
        if (hold) begin
            @(negedge clk);
            check("hold_idle_state", 32'(state_dbg), 32'(IDLE));
            check("hold_idle_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("hold_restart_busy", 32'(busy), 32'd1);
            n_done = 0;
            for (int k = 0; k < 100 && n_done == 0; k++) begin
                @(negedge clk);
                if (donee) n_done++;
            end
            check("hold_second_donee", 32'(n_done), 32'd1);
        end
        for (int a = 0; a < 64; a++) shadow[a] = exp_val(v, a);
        shadow_ok = 1;
    endtask

    // ---------------- test body ----------------
    initial begin
        vecs[0] = '{25'h0000000, 6'd0,  25'h0000000, 25'h0000000, 25'h0000000};
        vecs[1] = '{25'h0000000, 6'd5,  25'h0000002, 25'h0000000, 25'h0000012};
        vecs[2] = '{25'h1FFFFFF, 6'd0,  25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};
        vecs[3] = '{25'h0000000, 6'd0,  25'h000001F, 25'h0000000, 25'h000001F};
        vecs[4] = '{25'h0000000, 6'd63, 25'h0000001, 25'h0000000, 25'h0000009};
        vecs[5] = '{25'h0000000, 6'd10, 25'h1000000, 25'h0000000, 25'h1400000};
        vecs[6] = '{25'h0000000, 6'd20, 25'h0000003, 25'h0000000, 25'h000000B};

        rst     = 1'b0;
        start   = 1'b0;
        rd_addr = 6'd10;
        load_vec(0);
        #3;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", 32'(state_dbg), 32'(IDLE));

        run_pass(0, 1'b0);
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);
        run_pass(2, 1'b1);
        run_pass(3, 1'b0);
        run_pass(4, 1'b0);
        run_pass(6, 1'b0);

        // Abort an all-ones pass during cycle 30 of RUN.
        load_vec(2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1 check_outputs_zero("async_rst");
        @(negedge clk);
        check_outputs_zero("rst_held");
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_donee", 32'(donee), 32'd0);
            check("post_rst_we", 32'(write_enable), 32'd0);
        end
        for (int a = 0; a < 28; a++) shadow[a] = 25'h1FFFFFF;
        rd_addr = 6'd40;
        #1 check("buf_keep_40", 32'(rd_data), 32'(shadow[40]));
        rd_addr = 6'd5;
        #1 check("buf_keep_5", 32'(rd_data), 32'h1FFFFFF);
        rd_addr = 6'd28;
        #1 check("buf_keep_28", 32'(rd_data), 32'(shadow[28]));
        rd_addr = 6'd10;

        run_pass(5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
